// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared widths, snapshot types and the 16-bit saturator for the playback mixer.
package audio_pkg;
  localparam int SAMPLE_BITS = 16;
  localparam int VOLUME_BITS = 8;
  localparam int M_BUF_LEN = 32;
  localparam int M_IDX_BITS = $clog2(M_BUF_LEN);
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, WRITE} state_t;
  typedef struct packed {
    logic signed [SAMPLE_BITS-1:0] sample;
    logic [VOLUME_BITS-1:0] gain;
  } SourceControl_t;
  typedef struct packed {
    logic [VOLUME_BITS-1:0] master_vol;
    logic [M_IDX_BITS-1:0] rd_index;
  } MainControlReg_t;
  function automatic logic signed [SAMPLE_BITS-1:0] sat16(input logic signed [31:0] v);
    return v > 32767 ? 16'sh7fff : v < -32768 ? 16'sh8000 : v[SAMPLE_BITS-1:0];
  endfunction
endpackage

// File: rtl/audio_mixer_if.sv
// audio_mixer_if: write port into the circular master playback buffer.
interface audio_mixer_if;
  import audio_pkg::*;
  logic buf_we;
  logic [M_IDX_BITS-1:0] buf_addr;
  logic [SAMPLE_BITS-1:0] buf_data;
  modport master(output buf_we, buf_addr, buf_data);
  modport slave(input buf_we, buf_addr, buf_data);
endinterface

// File: rtl/audio_mixer_sync_edge_det.sv
// sync_edge_det: two-flop synchroniser with a one-cycle pulse on each synchronised falling edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_fall
);
  logic [2:0] r_sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_d};
  assign o_fall = r_sh[2] & ~r_sh[1];
endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: per-frame sequential multiply-accumulate of N_CH sources, master volume,
// saturation to 16 bits and one write into the playback ring, with clip and overrun status.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int N_CH = 6,
  parameter int LAG = 1,
  parameter int CLIP_HOLD = 4800
) (
  input  logic mclk,
  input  logic rstn,
  input  logic pblrc,
  input  logic [N_CH*SAMPLE_BITS-1:0] samples,
  input  logic [N_CH*VOLUME_BITS-1:0] gains,
  input  logic [VOLUME_BITS-1:0] master_vol,
  input  logic [M_IDX_BITS-1:0] rd_index,
  audio_mixer_if.master wr,
  output logic busy,
  output logic clip,
  output logic overrun
);
  localparam int ACC_W = SAMPLE_BITS + VOLUME_BITS + $clog2(N_CH) + 1;
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int HOLD_W = $clog2(CLIP_HOLD + 1);
  state_t r_state, w_next;
  SourceControl_t r_src [N_CH];
  MainControlReg_t r_main;
  logic [CH_W-1:0] r_ch;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-VOLUME_BITS:0] r_mix;
  logic [HOLD_W-1:0] r_hold;
  logic r_over;
  logic w_fs, w_we, w_sat, w_last;
  logic signed [SAMPLE_BITS+VOLUME_BITS:0] w_prod;
  logic signed [ACC_W-VOLUME_BITS-1:0] w_acc_sh;
  logic signed [ACC_W:0] w_scaled;
  logic signed [31:0] w_mix32;
  sync_edge_det u_sync (.clk(mclk), .rst_n(rstn), .i_d(pblrc), .o_fall(w_fs));
  assign w_last = r_ch == CH_W'(N_CH - 1);
  // gains are unsigned, so widen with a zero sign bit before the signed multiplies
  assign w_prod = $signed(r_src[r_ch].sample) * $signed({1'b0, r_src[r_ch].gain});
  assign w_acc_sh = r_acc[ACC_W-1:VOLUME_BITS];
  assign w_scaled = w_acc_sh * $signed({1'b0, r_main.master_vol});
  assign w_mix32 = 32'(r_mix);
  assign w_sat = w_mix32 > 32767 || w_mix32 < -32768;
  assign w_we = r_state == WRITE;
  always_comb begin
    w_next = r_state == IDLE ? (w_fs ? ACCUM : IDLE) :
             r_state == ACCUM ? (w_last ? SCALE : ACCUM) :
             r_state == SCALE ? WRITE : IDLE;
  end
  always_ff @(posedge mclk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge mclk or negedge rstn)
    if (!rstn) begin
      for (int k = 0; k < N_CH; k++) r_src[k] <= '0;
      r_main <= '0;
      r_ch <= '0;
      r_acc <= '0;
      r_mix <= '0;
      r_hold <= '0;
      r_over <= 1'b0;
    end else begin
      if (w_fs && r_state == IDLE) begin
        for (int k = 0; k < N_CH; k++)
          r_src[k] <= '{samples[k*SAMPLE_BITS +: SAMPLE_BITS], gains[k*VOLUME_BITS +: VOLUME_BITS]};
        r_main <= '{master_vol, rd_index};
        r_acc <= '0;
        r_ch <= '0;
      end
      if (r_state == ACCUM) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        r_ch <= r_ch + 1'b1;
      end
      if (r_state == SCALE) r_mix <= w_scaled[ACC_W:VOLUME_BITS];
      if (w_fs && r_state != IDLE) r_over <= 1'b1;
      // a saturating write reloads the hold even when a frame edge lands in the same cycle
      if (w_we && w_sat) r_hold <= HOLD_W'(CLIP_HOLD);
      else if (w_fs && r_hold != '0) r_hold <= r_hold - 1'b1;
    end
  always_comb begin
    wr.buf_we = w_we;
    wr.buf_addr = w_we ? r_main.rd_index - M_IDX_BITS'(LAG) : '0;
    wr.buf_data = w_we ? sat16(w_mix32) : '0;
  end
  assign busy = r_state != IDLE;
  assign clip = r_hold != '0;
  assign overrun = r_over;
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed frames with hand-computed mixes, latency, wrap, clip hold, overrun and reset.
module tb_audio_mixer;
  import audio_pkg::*;
  localparam int N_CH = 6;
  logic mclk = 1'b0;
  logic rstn = 1'b0;
  logic pblrc = 1'b1;
  logic [N_CH*SAMPLE_BITS-1:0] samples = '0;
  logic [N_CH*VOLUME_BITS-1:0] gains = '0;
  logic [VOLUME_BITS-1:0] master_vol = '0;
  logic [M_IDX_BITS-1:0] rd_index = '0;
  logic busy, clip, overrun;
  int n_chk = 0;
  int n_pass = 0;
  int lat, nwe, addr, data;
  audio_mixer_if bus ();
  audio_mixer #(.N_CH(N_CH), .LAG(1), .CLIP_HOLD(3)) dut (
    .mclk(mclk), .rstn(rstn), .pblrc(pblrc), .samples(samples), .gains(gains),
    .master_vol(master_vol), .rd_index(rd_index), .wr(bus.master),
    .busy(busy), .clip(clip), .overrun(overrun)
  );
  always #5 mclk = ~mclk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic set_ch(input int k, input int s, input int g);
    samples[k*SAMPLE_BITS +: SAMPLE_BITS] = s[SAMPLE_BITS-1:0];
    gains[k*VOLUME_BITS +: VOLUME_BITS] = g[VOLUME_BITS-1:0];
  endtask
  task automatic set_all(input int s, input int g);
    for (int k = 0; k < N_CH; k++) set_ch(k, s, g);
  endtask
  // mode 1: scramble inputs mid-ACCUM; 2: second pblrc fall 4 cycles later; 3: reset pulse in ACCUM cycle 3
  task automatic frame(input int mode, output int o_lat, output int o_nwe, output int o_addr, output int o_data);
    o_lat = -1; o_nwe = 0; o_addr = 0; o_data = 0;
    pblrc = 1'b1;
    repeat (4) @(negedge mclk);
    pblrc = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge mclk);
      if (mode == 1 && i == 4) begin set_all(-20000, 255); master_vol = 8'd1; rd_index = 5'd17; end
      if (mode == 2 && i == 2) pblrc = 1'b1;
      if (mode == 2 && i == 4) pblrc = 1'b0;
      if (mode == 3 && i == 5) rstn = 1'b0;
      if (mode == 3 && i == 6) rstn = 1'b1;
      if (bus.buf_we) begin
        o_nwe++;
        if (o_lat < 0) begin
          o_lat = i;
          o_addr = int'(bus.buf_addr);
          o_data = int'($signed(bus.buf_data));
        end
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge mclk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(bus.buf_we), 0);
    chk("rst_addr", int'(bus.buf_addr), 0);
    chk("rst_data", int'(bus.buf_data), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_over", int'(overrun), 0);
    rstn = 1'b1;
    @(negedge mclk);
    set_all(0, 0); set_ch(0, 1000, 128); master_vol = 8'd128; rd_index = 5'd5;
    frame(0, lat, nwe, addr, data);
    chk("single_lat_ok", int'(lat >= 10 && lat <= 11), 1);
    chk("single_nwe", nwe, 1);
    chk("single_addr", addr, 4);
    chk("single_data", data, 250);
    chk("single_clip", int'(clip), 0);
    set_all(0, 0); set_ch(0, -3, 128); master_vol = 8'd128; rd_index = 5'd0;
    frame(0, lat, nwe, addr, data);
    chk("floor_data", data, -1);
    chk("wrap_addr", addr, 31);
    master_vol = 8'd255;
    frame(0, lat, nwe, addr, data);
    chk("floor255_data", data, -2);
    set_all(12345, 0); master_vol = 8'd255; rd_index = 5'd3;
    frame(0, lat, nwe, addr, data);
    chk("gain0_data", data, 0);
    chk("gain0_nwe", nwe, 1);
    set_all(30000, 255); master_vol = 8'd255; rd_index = 5'd10;
    frame(0, lat, nwe, addr, data);
    chk("satp_data", data, 32767);
    chk("satp_addr", addr, 9);
    chk("satp_clip", int'(clip), 1);
    set_all(0, 0);
    frame(0, lat, nwe, addr, data);
    chk("hold1_clip", int'(clip), 1);
    chk("hold1_data", data, 0);
    frame(0, lat, nwe, addr, data);
    chk("hold2_clip", int'(clip), 1);
    frame(0, lat, nwe, addr, data);
    chk("hold3_clip", int'(clip), 0);
    set_all(-32768, 255); master_vol = 8'd255; rd_index = 5'd1;
    frame(0, lat, nwe, addr, data);
    chk("satn_data", data, -32768);
    chk("satn_addr", addr, 0);
    chk("satn_clip", int'(clip), 1);
    set_all(0, 0); set_ch(0, 1000, 128); master_vol = 8'd128; rd_index = 5'd7;
    frame(1, lat, nwe, addr, data);
    chk("snap_data", data, 250);
    chk("snap_addr", addr, 6);
    chk("snap_over", int'(overrun), 0);
    set_all(0, 0); set_ch(0, 1000, 128); master_vol = 8'd128; rd_index = 5'd20;
    frame(2, lat, nwe, addr, data);
    chk("ovr_nwe", nwe, 1);
    chk("ovr_data", data, 250);
    chk("ovr_addr", addr, 19);
    chk("ovr_flag", int'(overrun), 1);
    frame(0, lat, nwe, addr, data);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_next_nwe", nwe, 1);
    frame(3, lat, nwe, addr, data);
    chk("rstmid_nwe", nwe, 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_over", int'(overrun), 0);
    chk("rstmid_clip", int'(clip), 0);
    chk("rstmid_data", int'(bus.buf_data), 0);
    frame(0, lat, nwe, addr, data);
    chk("after_rst_nwe", nwe, 1);
    chk("after_rst_data", data, 250);
    chk("after_rst_addr", addr, 19);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
